display_digit_sequencer: RTL and testbench

- Sits directly upstream of the seg7 decoder in tt_um_jrb8_computer and produces the 4-bit digit code that seg7 turns into segments.
- Latches the byte the CPU writes to its output port and converts it to decimal with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes sign, hundreds, tens and ones onto the single digit bus, dwelling MAX_COUNT clocks per position.

---
 rtl/display_digit_sequencer_if.sv | 22 ++
 rtl/display_digit_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_display_digit_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/display_digit_sequencer_if.sv
// Display-port bundle: CPU write strobe and data in, multiplexed digit stream and busy out.
// The master side drives the write; the slave side is the sequencer.
interface display_digit_sequencer_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       signed_mode;
    logic       busy;
    logic [3:0] digit;
    logic [1:0] digit_idx;
    logic       blank;
    logic       minus;

    modport master (
        output wr_en, wr_data, signed_mode,
        input  busy, digit, digit_idx, blank, minus
    );

    modport slave (
        input  wr_en, wr_data, signed_mode,
        output busy, digit, digit_idx, blank, minus
    );
endinterface

// File: rtl/display_digit_sequencer.sv
// Binary-to-BCD (shift-add-3) converter plus scanned sign/hundreds/tens/ones digit mux; 11 clocks write-to-display.
// No backpressure: one-deep pending register, a newer write overwrites an unconverted one.
module display_digit_sequencer #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
    parameter bit          LZ_BLANK  = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    display_digit_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [7:0]  pend_dat_q;
    logic        pend_sgn_q;
    logic        pend_vld_q;

    logic [7:0]  mag_q, mag_d;
    logic [9:0]  bcd_q, bcd_d;
    logic        neg_q, neg_d;
    logic [2:0]  iter_q, iter_d;
    logic [8:0]  bcd_adj;
    logic        pend_neg;

    logic [1:0]  disp_h_q;
    logic [3:0]  disp_t_q;
    logic [3:0]  disp_o_q;
    logic        disp_neg_q;

    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        cnt_wrap;

    logic        busy;
    logic        load_en;
    logic        shift_en;
    logic        commit_en;

    logic [3:0]  digit;
    logic        blank;
    logic        minus;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pend_vld_q) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SHIFT;
            ST_SHIFT:  if (iter_q == 3'd7) state_d = ST_COMMIT;
            // A write landing on the commit edge chains straight into the next load.
            ST_COMMIT: state_d = (pend_vld_q || bus.wr_en) ? ST_LOAD : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        load_en   = (state_q == ST_LOAD);
        shift_en  = (state_q == ST_SHIFT);
        commit_en = (state_q == ST_COMMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dat_q <= 8'd0;
            pend_sgn_q <= 1'b0;
            pend_vld_q <= 1'b0;
        end else if (bus.wr_en) begin
            pend_dat_q <= bus.wr_data;
            pend_sgn_q <= bus.signed_mode;
            pend_vld_q <= 1'b1;
        end else if (load_en) begin
            pend_vld_q <= 1'b0;
        end
    end

    // Hundreds never exceeds 2, so only tens and ones need the add-3 correction.
    always_comb begin
        pend_neg = pend_sgn_q & pend_dat_q[7];
        bcd_adj  = {bcd_q[8], add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        iter_d   = iter_q;
        if (load_en) begin
            neg_d  = pend_neg;
            mag_d  = pend_neg ? (~pend_dat_q + 8'd1) : pend_dat_q;
            bcd_d  = 10'd0;
            iter_d = 3'd0;
        end else if (shift_en) begin
            {bcd_d, mag_d} = {bcd_adj, mag_q, 1'b0};
            iter_d         = iter_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q  <= 8'd0;
            bcd_q  <= 10'd0;
            neg_q  <= 1'b0;
            iter_q <= 3'd0;
        end else begin
            mag_q  <= mag_d;
            bcd_q  <= bcd_d;
            neg_q  <= neg_d;
            iter_q <= iter_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_h_q   <= 2'd0;
            disp_t_q   <= 4'd0;
            disp_o_q   <= 4'd0;
            disp_neg_q <= 1'b0;
        end else if (commit_en) begin
            disp_h_q   <= bcd_q[9:8];
            disp_t_q   <= bcd_q[7:4];
            disp_o_q   <= bcd_q[3:0];
            disp_neg_q <= neg_q;
        end
    end

    always_comb begin
        cnt_wrap = (cnt_q == MAX_COUNT - 24'd1);
        cnt_d    = cnt_wrap ? 24'd0 : cnt_q + 24'd1;
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 24'd0;
            idx_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        digit = 4'd0;
        blank = 1'b0;
        minus = 1'b0;
        case (idx_q)
            2'd0: digit = disp_o_q;
            2'd1: begin
                digit = disp_t_q;
                blank = LZ_BLANK && (disp_h_q == 2'd0) && (disp_t_q == 4'd0);
            end
            2'd2: begin
                digit = {2'b00, disp_h_q};
                blank = LZ_BLANK && (disp_h_q == 2'd0);
            end
            default: begin
                minus = disp_neg_q;
                blank = !disp_neg_q;
            end
        endcase
    end

    assign bus.busy      = busy;
    assign bus.digit     = digit;
    assign bus.digit_idx = idx_q;
    assign bus.blank     = blank;
    assign bus.minus     = minus;

endmodule

// File: tb/tb_display_digit_sequencer.sv
// Directed bench: fast-scan blanking instance (a) and slow-scan unblanked instance (b) checked every cycle.
module tb_display_digit_sequencer;

    logic clk;
    logic rst_n;

    display_digit_sequencer_if bus_a ();
    display_digit_sequencer_if bus_b ();

    display_digit_sequencer #(.MAX_COUNT(24'd1), .LZ_BLANK(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    display_digit_sequencer #(.MAX_COUNT(24'd3), .LZ_BLANK(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_chk;
    int n_err;
    int cyc;
    int val_a, val_b;
    bit neg_a, neg_b;
    bit busy_a, busy_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected {digit, blank, minus} for a decimal value at a given scan position.
    function automatic logic [5:0] exp_out(input int val, input bit neg, input int idx, input bit lz);
        int  h, t, o;
        logic [3:0] d;
        logic b, m;
        h = val / 100;
        t = (val / 10) % 10;
        o = val % 10;
        d = 4'd0;
        b = 1'b0;
        m = 1'b0;
        case (idx)
            0: d = 4'(o);
            1: begin d = 4'(t); b = lz && (h == 0) && (t == 0); end
            2: begin d = 4'(h); b = lz && (h == 0); end
            default: begin m = neg; b = !neg; end
        endcase
        return {d, b, m};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) cyc++;
    endtask

    task automatic check_all();
        int ia, ib;
        ia = cyc % 4;
        ib = (cyc / 3) % 4;
        chk("a_busy", 16'(bus_a.busy), 16'(busy_a));
        chk("a_idx",  16'(bus_a.digit_idx), 16'(ia));
        chk("a_out",  16'({bus_a.digit, bus_a.blank, bus_a.minus}), 16'(exp_out(val_a, neg_a, ia, 1'b1)));
        chk("b_busy", 16'(bus_b.busy), 16'(busy_b));
        chk("b_idx",  16'(bus_b.digit_idx), 16'(ib));
        chk("b_out",  16'({bus_b.digit, bus_b.blank, bus_b.minus}), 16'(exp_out(val_b, neg_b, ib, 1'b0)));
    endtask

    task automatic wr_a(input logic [7:0] d, input logic s, input int new_val, input bit new_neg);
        bus_a.wr_en       = 1'b1;
        bus_a.wr_data     = d;
        bus_a.signed_mode = s;
        tick();
        bus_a.wr_en = 1'b0;
        check_all();
        for (int i = 1; i <= 13; i++) begin
            tick();
            busy_a = (i <= 10);
            if (i == 11) begin
                val_a = new_val;
                neg_a = new_neg;
            end
            check_all();
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        val_a = 0; val_b = 0; neg_a = 0; neg_b = 0; busy_a = 0; busy_b = 0;
        rst_n = 1'b0;
        bus_a.wr_en = 1'b0; bus_a.wr_data = 8'h00; bus_a.signed_mode = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_data = 8'h00; bus_b.signed_mode = 1'b0;

        // Reset state and idle scanning.
        tick();
        tick();
        check_all();
        rst_n = 1'b1;
        check_all();
        for (int i = 0; i < 8; i++) begin
            tick();
            check_all();
        end

        // Single conversions: unsigned max, signed min, small negative, signed positive.
        wr_a(8'hFF, 1'b0, 255, 1'b0);
        wr_a(8'h80, 1'b1, 128, 1'b1);
        wr_a(8'hF6, 1'b1, 10,  1'b1);
        wr_a(8'h7F, 1'b1, 127, 1'b0);

        // Two writes during a conversion: only the latest is converted, no idle gap.
        bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h07; bus_a.signed_mode = 1'b0;
        tick();
        bus_a.wr_en = 1'b0;
        check_all();
        for (int i = 1; i <= 23; i++) begin
            bus_a.wr_en = 1'b0;
            if (i == 3) begin bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h2A; end
            if (i == 5) begin bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h63; end
            tick();
            busy_a = (i <= 20);
            if (i == 11) begin val_a = 7;  neg_a = 1'b0; end
            if (i == 21) begin val_a = 99; neg_a = 1'b0; end
            check_all();
        end
        bus_a.wr_en = 1'b0;

        // No leading-zero blanking with a 3-clock dwell.
        bus_b.wr_en = 1'b1; bus_b.wr_data = 8'h05; bus_b.signed_mode = 1'b0;
        tick();
        bus_b.wr_en = 1'b0;
        check_all();
        for (int i = 1; i <= 14; i++) begin
            tick();
            busy_b = (i <= 10);
            if (i == 11) val_b = 5;
            check_all();
        end

        // Reset in the middle of a conversion discards it.
        bus_a.wr_en = 1'b1; bus_a.wr_data = 8'hC8; bus_a.signed_mode = 1'b0;
        tick();
        bus_a.wr_en = 1'b0;
        check_all();
        for (int i = 1; i <= 5; i++) begin
            tick();
            busy_a = 1'b1;
            check_all();
        end
        rst_n = 1'b0;
        #1;
        cyc = 0;
        val_a = 0; neg_a = 0; busy_a = 0;
        val_b = 0; neg_b = 0; busy_b = 0;
        check_all();
        tick();
        check_all();
        rst_n = 1'b1;
        check_all();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_all();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
